// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU, single-cycle ops plus iterative shift-add MUL
module alu_multicycle #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt, alu_res;
  logic [SHW-1:0] cnt, shamt;
  assign busy_o = state == MUL;
  assign shamt = data2_i[SHW-1:0];
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      3'b000: alu_res = data1_i + data2_i;
      3'b001: alu_res = data1_i - data2_i;
      3'b010: alu_res = data1_i & data2_i;
      3'b011: alu_res = data1_i ^ data2_i;
      3'b100: alu_res = data1_i << shamt;
      3'b101: alu_res = $signed(data1_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end
  // flush overrides both a pending accept and an in-flight multiply, including its final edge
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      data_o <= '0;
      valid_o <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i && !flush_i) begin
          if (ALUCtrl_i == 3'b110) begin
            mcand <= data1_i;
            mplier <= data2_i;
            acc <= '0;
            cnt <= '0;
            state <= MUL;
          end else begin
            data_o <= alu_res;
            valid_o <= 1'b1;
          end
        end
      end else if (flush_i) begin
        state <= IDLE;
      end else begin
        acc <= acc_nxt;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          data_o <= acc_nxt;
          valid_o <= 1'b1;
          state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0, dout;
  logic valid, busy;
  int vectors = 0, errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(op),
    .data1_i(a), .data2_i(b), .flush_i(flush),
    .data_o(dout), .valid_o(valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x ^ y;
      3'd4: return x << y[4:0];
      3'd5: return $signed(x) >>> y[4:0];
      3'd6: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (dout !== 32'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h valid=%b busy=%b, want 0/0/0", dout, valid, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] ops[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    logic [31:0] xs[6] = '{32'd5, 32'd5, 32'hF0F0F0F0, 32'h1, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] ys[6] = '{32'd7, 32'd7, 32'hFF00FF00, 32'h24, 32'h4, 32'h0000FFFF};
    logic [31:0] ex[6] = '{32'hC, 32'hFFFFFFFE, 32'hF000F000, 32'h10, 32'hF8000000, 32'hFFFF0000};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; op = ops[i]; a = xs[i]; b = ys[i];
      @(negedge clk);
      vectors++;
      if (dout !== ex[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL basic[%0d] op=%0d: data=%h valid=%b, want %h/1", i, ops[i], dout, valid, ex[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || dout !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL basic_idle: data=%h valid=%b, want ffff0000/0", dout, valid);
    end
  endtask

  task automatic test_random_single();
    logic [31:0] e;
    for (int i = 0; i < 40; i++) begin
      start = 1'b1;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6) op = 3'd7;
      a = $urandom; b = $urandom;
      e = model(op, a, b);
      @(negedge clk);
      vectors++;
      if (dout !== e || valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_single[%0d] op=%0d a=%h b=%h: data=%h valid=%b busy=%b, want %h/1/0", i, op, a, b, dout, valid, busy, e);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] xs[6] = '{32'd7, 32'h00010000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] ys[6] = '{32'hFFFFFFFD, 32'h00010000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] e;
    for (int i = 3; i < 6; i++) begin
      xs[i] = $urandom; ys[i] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; op = 3'd6; a = xs[i]; b = ys[i];
      e = model(3'd6, xs[i], ys[i]);
      if (i == 0 && e !== 32'hFFFFFFEB) begin
        vectors++; errors++;
        $display("FAIL mul_model: got %h, want ffffffeb", e);
      end
      for (int k = 1; k <= 32; k++) begin
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
          errors++;
          $display("FAIL mul[%0d] cycle %0d: busy=%b valid=%b, want 1/0", i, k, busy, valid);
        end
        // requests and operand changes while busy must be ignored
        start = (k < 32); op = 3'd0; a = $urandom; b = $urandom;
      end
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || valid !== 1'b1 || dout !== e) begin
        errors++;
        $display("FAIL mul[%0d] done %h*%h: data=%h valid=%b busy=%b, want %h/1/0", i, xs[i], ys[i], dout, valid, busy, e);
      end
      @(negedge clk);
      vectors++;
      if (valid !== 1'b0 || dout !== e) begin
        errors++;
        $display("FAIL mul[%0d] after: data=%h valid=%b, want %h/0", i, dout, valid, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] keep;
    start = 1'b1; op = 3'd0; a = 32'h1234; b = 32'h0;
    @(negedge clk);
    keep = dout;
    start = 1'b1; op = 3'd6; a = 32'd9; b = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || dout !== keep || keep !== 32'h1234) begin
      errors++;
      $display("FAIL flush_mid: data=%h valid=%b busy=%b, want 00001234/0/0", dout, valid, busy);
    end
    flush = 1'b0; start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    vectors++;
    if (dout !== 32'd2 || valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_add: data=%h valid=%b, want 00000002/1", dout, valid);
    end
    flush = 1'b1; op = 3'd0; a = 32'd50; b = 32'd50;
    @(negedge clk);
    vectors++;
    if (dout !== 32'd2 || valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: data=%h valid=%b, want 00000002/0", dout, valid);
    end
    flush = 1'b0; start = 1'b1; op = 3'd6; a = 32'd3; b = 32'd3;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || dout !== 32'd2) begin
      errors++;
      $display("FAIL flush_final: data=%h valid=%b busy=%b, want 00000002/0/0", dout, valid, busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    start = 1'b1; op = 3'd6; a = 32'd11; b = 32'd13;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: data=%h valid=%b busy=%b, want 0/0/0", dout, valid, busy);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (dout !== 32'd7 || valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_then_add: data=%h valid=%b busy=%b, want 00000007/1/0", dout, valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_single();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
